// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-address and read-data channels as seen by the arbiter (master side)
// and the memory system (slave side).
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Round-robin N-master AXI4 read arbiter, one burst outstanding, arid = master index.
// Optional response/length checker with sticky err output: define AXI_ARB_RESP_CHECK_EN.
module axi_rd_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]      m_arlen,
  input  logic [NUM_MASTERS*3-1:0]      m_arsize,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  output logic [NUM_MASTERS-1:0]        m_arready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_rlast,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  input  logic [NUM_MASTERS-1:0]        m_rready,
`ifdef AXI_ARB_RESP_CHECK_EN
  output logic                          err,
`endif
  axi_rd_arbiter_if.master              axi
);

  localparam int GW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [GW-1:0]     pick;
  logic              found;
  int                idx;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [ID_W-1:0]   arid_q;
  logic              arvalid_q;
  logic              beat_hs;
  logic              unused_bits;

  // Round-robin scan starting one past the previous winner.
  // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(last_grant) + k) % NUM_MASTERS;
      if (!found && m_arvalid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign beat_hs = (state == DATA) && axi.rvalid && axi.rready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_MASTERS - 1);
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arid_q     <= '0;
      arvalid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant     <= pick;
            araddr_q  <= m_araddr[pick*ADDR_W +: ADDR_W];
            arlen_q   <= m_arlen[pick*8 +: 8];
            arsize_q  <= m_arsize[pick*3 +: 3];
            arid_q    <= ID_W'(pick);
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat_hs && axi.rlast) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address accept and beat valid are steered to the granted master only.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    if (state == ADDR) m_arready[grant] = axi.arready;
    if (state == DATA) m_rvalid[grant]  = axi.rvalid;
  end

  assign axi.rready  = (state == DATA) && m_rready[grant];
  assign m_rdata     = axi.rdata;
  assign m_rlast     = axi.rlast;

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arvalid = arvalid_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;

  // Ordering is guaranteed by the single outstanding burst, so rid is ignored.
  assign unused_bits = ^{axi.rid, axi.rresp};

`ifdef AXI_ARB_RESP_CHECK_EN
  logic [7:0] beat_cnt;

  // beat_cnt is the index of the beat currently presented; the arlen_q-th must carry rlast.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ADDR && axi.arready) beat_cnt <= '0;
      else if (beat_hs)                 beat_cnt <= beat_cnt + 8'd1;
      if (beat_hs && ((axi.rresp != 2'b00) || (axi.rlast != (beat_cnt == arlen_q))))
        err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised bench for axi_rd_arbiter (3 masters) against a transaction-level model.
module tb_axi_rd_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N*AW-1:0] m_araddr;
  logic [N*8-1:0]  m_arlen;
  logic [N*3-1:0]  m_arsize;
  logic [N-1:0]    m_arvalid;
  logic [N-1:0]    m_arready;
  logic [DW-1:0]   m_rdata;
  logic            m_rlast;
  logic [N-1:0]    m_rvalid;
  logic [N-1:0]    m_rready;
`ifdef AXI_ARB_RESP_CHECK_EN
  logic            err;
`endif

  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) axi ();

  axi_rd_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
`ifdef AXI_ARB_RESP_CHECK_EN
    .err       (err),
`endif
    .axi       (axi)
  );

  initial forever #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus policy
  int          budget [N];
  int          req_prob, rr_prob, ar_prob, rv_prob, err_prob;
  int          fix_len, early_last, stall;
  bit          fix_addr_en;
  logic [31:0] fix_addr;

  // Transaction-level model
  bit          busy, ar_done;
  int          owner, last_g, beat;
  logic [31:0] e_addr;
  logic [7:0]  e_len;
  logic [2:0]  e_size;
  int          grants [$];
  int          beats_to [N];
  bit          err_exp;
  logic [N-1:0] ar_hs_f;
  bit          beat_f;

  // Memory responder
  bit          mem_act;
  int          mem_beat;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;

  logic [N-1:0] x_arready, x_rvalid;
  logic         x_arvalid, x_rready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return (a + 32'(b) * 32'd4) ^ 32'h5A5A_0000;
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_g + k) % N;
      if (m_arvalid[i]) return i;
    end
    return -1;
  endfunction

  // Compare on the falling edge, then advance the model with what the rising edge will see.
  always @(negedge aclk) begin
    if (aresetn) begin
      x_arready = '0;
      x_rvalid  = '0;
      x_arvalid = 1'b0;
      x_rready  = 1'b0;
      if (busy && !ar_done) begin
        x_arvalid = 1'b1;
        x_arready[owner] = axi.arready;
      end
      if (busy && ar_done) begin
        x_rvalid[owner] = axi.rvalid;
        x_rready = m_rready[owner];
      end
      check("arvalid", 64'(axi.arvalid), 64'(x_arvalid));
      check("m_arready", 64'(m_arready), 64'(x_arready));
      check("m_rvalid", 64'(m_rvalid), 64'(x_rvalid));
      check("rready", 64'(axi.rready), 64'(x_rready));
      check("ar_consts", 64'({axi.arburst, axi.arlock, axi.arcache, axi.arprot}), 64'(11'b01_00_0000_000));
      if (busy && !ar_done) begin
        check("arid", 64'(axi.arid), 64'(owner));
        check("araddr", 64'(axi.araddr), 64'(e_addr));
        check("arlen", 64'(axi.arlen), 64'(e_len));
        check("arsize", 64'(axi.arsize), 64'(e_size));
      end
      if (axi.rvalid) begin
        check("m_rdata", 64'(m_rdata), 64'(axi.rdata));
        check("m_rlast", 64'(m_rlast), 64'(axi.rlast));
      end
`ifdef AXI_ARB_RESP_CHECK_EN
      check("err", 64'(err), 64'(err_exp));
`endif
      ar_hs_f = '0;
      beat_f  = 1'b0;
      if (!busy) begin
        if (|m_arvalid) begin
          owner   = rr_pick();
          busy    = 1'b1;
          ar_done = 1'b0;
          e_addr  = m_araddr[owner*AW +: AW];
          e_len   = m_arlen[owner*8 +: 8];
          e_size  = m_arsize[owner*3 +: 3];
        end
      end else if (!ar_done) begin
        if (axi.arready) begin
          ar_done = 1'b1;
          beat    = 0;
          ar_hs_f[owner] = 1'b1;
          grants.push_back(owner);
          mem_addr = axi.araddr;
          mem_len  = axi.arlen;
        end
      end else if (axi.rvalid && m_rready[owner]) begin
        beat_f = 1'b1;
        check("rdata_order", 64'(m_rdata), 64'(beat_data(e_addr, beat)));
        beats_to[owner]++;
        if (axi.rresp != 2'b00 || (axi.rlast != (beat == int'(e_len)))) err_exp = 1'b1;
        if (axi.rlast) begin
          busy   = 1'b0;
          last_g = owner;
        end
        beat++;
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (ar_hs_f[i]) m_arvalid[i] = 1'b0;
      if (!m_arvalid[i] && budget[i] > 0 && int'($urandom_range(99)) < req_prob) begin
        budget[i]--;
        m_arvalid[i] = 1'b1;
        m_araddr[i*AW +: AW] = fix_addr_en ? fix_addr : ($urandom & 32'hFFFF_FFF0);
        m_arlen[i*8 +: 8]    = (fix_len >= 0) ? 8'(fix_len) : 8'($urandom_range(7));
        m_arsize[i*3 +: 3]   = 3'($urandom_range(2));
      end
      m_rready[i] = (stall > 0) ? 1'b0 : (int'($urandom_range(99)) < rr_prob);
    end
    if (stall > 0) stall--;
    axi.arready = int'($urandom_range(99)) < ar_prob;
    if (beat_f) begin
      if (axi.rlast) mem_act = 1'b0;
      else mem_beat++;
    end
    if (|ar_hs_f) begin
      mem_act  = 1'b1;
      mem_beat = 0;
    end
    if (!mem_act) begin
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rresp  = 2'b00;
    end else if (!(axi.rvalid && !beat_f)) begin
      axi.rvalid = int'($urandom_range(99)) < rv_prob;
      axi.rdata  = beat_data(mem_addr, mem_beat);
      axi.rlast  = (mem_beat == int'(mem_len)) || (mem_beat == early_last);
      axi.rresp  = (int'($urandom_range(99)) < err_prob) ? 2'b10 : 2'b00;
      axi.rid    = IW'(mem_beat);
    end
  endtask

  task automatic drive_cycle();
    @(posedge aclk);
    #1;
    drive();
  endtask

  task automatic model_reset();
    busy = 1'b0; ar_done = 1'b0; last_g = N - 1; beat = 0; owner = 0;
    err_exp = 1'b0; ar_hs_f = '0; beat_f = 1'b0; mem_act = 1'b0; mem_beat = 0;
    grants.delete();
    for (int i = 0; i < N; i++) begin
      beats_to[i] = 0;
      budget[i]   = 0;
    end
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_rready = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
    axi.rdata = '0; axi.rid = '0;
    stall = 0; fix_addr_en = 1'b0; fix_len = -1; early_last = -1;
    req_prob = 100; rr_prob = 100; ar_prob = 100; rv_prob = 100; err_prob = 0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    check("rst_arvalid", 64'(axi.arvalid), 64'd0);
    check("rst_ctrl", 64'({m_arready, m_rvalid, axi.rready}), 64'd0);
    check("rst_fields", 64'({axi.arid, axi.arlen, axi.arsize}), 64'd0);
    check("rst_araddr", 64'(axi.araddr), 64'd0);
  endtask

  task automatic wait_data(input int min_beat, input int max_cyc, input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      drive_cycle();
      ok = busy && ar_done && beat >= min_beat;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    bit ok;
    int left;
    ok = 1'b0;
    for (int c = 0; c < max_cyc && !ok; c++) begin
      drive_cycle();
      left = 0;
      for (int i = 0; i < N; i++) left += budget[i];
      ok = !busy && (m_arvalid == '0) && left == 0;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic check_grants(input string name, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    check({name, "_cnt"}, 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check(name, 64'((i < grants.size()) ? grants[i] : -1), 64'(e[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // First burst: latency, fixed fields, arready held off, 4 beats to master 0.
    fix_addr_en = 1'b1; fix_addr = 32'h1FC0_0000; fix_len = 3; ar_prob = 0;
    budget[0] = 1;
    drive_cycle();
    @(negedge aclk); #1;
    check("lat_cycle_n", 64'(axi.arvalid), 64'd0);
    drive_cycle();
    @(negedge aclk); #1;
    check("lat_cycle_n1", 64'(axi.arvalid), 64'd1);
    check("first_araddr", 64'(axi.araddr), 64'h1FC0_0000);
    check("first_arid", 64'(axi.arid), 64'd0);
    drive_cycle();
    ar_prob = 100;
    wait_idle(100, "first_done");
    check("first_beats_m0", 64'(beats_to[0]), 64'd4);
    check("first_beats_m1", 64'(beats_to[1] + beats_to[2]), 64'd0);

    // Masters 0 and 1 compete: strict alternation.
    do_reset();
    fix_len = 0; budget[0] = 2; budget[1] = 2;
    wait_idle(100, "alt_done");
    check_grants("alt_order", 0, 1, 0, 1);

    // Master-side back-pressure mid-burst.
    do_reset();
    fix_len = 3; budget[0] = 1;
    wait_data(1, 50, "stall_reach");
    stall = 3;
    wait_idle(100, "stall_done");
    check("stall_beats", 64'(beats_to[0]), 64'd4);

    // Late requesters wait for the running burst; then rotation 1, 2, 0.
    do_reset();
    fix_len = 2; budget[0] = 1;
    wait_data(0, 50, "late_reach");
    budget[0] = 1; budget[1] = 1; budget[2] = 1;
    wait_idle(200, "late_done");
    check_grants("late_order", 0, 1, 2, 0);

    // Asynchronous reset after two beats of an 8-beat burst.
    do_reset();
    fix_len = 7; budget[0] = 1;
    wait_data(2, 50, "rst_reach");
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_ctrl", 64'({axi.arvalid, axi.rready, m_arready, m_rvalid}), 64'd0);
    check("arst_fields", 64'({axi.arid, axi.arlen, axi.arsize}), 64'd0);
    check("arst_araddr", 64'(axi.araddr), 64'd0);
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    fix_len = 0; budget[0] = 1; budget[1] = 1; budget[2] = 1;
    wait_idle(100, "arst_after");
    check("arst_first_grant", 64'((grants.size() > 0) ? grants[0] : -1), 64'd0);

    // Random traffic in two flavours of back-pressure.
    for (int r = 0; r < 2; r++) begin
      do_reset();
      req_prob = (r == 0) ? 40 : 90;
      rr_prob  = (r == 0) ? 70 : 50;
      ar_prob  = (r == 0) ? 60 : 30;
      rv_prob  = (r == 0) ? 75 : 50;
`ifdef AXI_ARB_RESP_CHECK_EN
      err_prob = 5;
`endif
      for (int i = 0; i < N; i++) budget[i] = 200;
      repeat (3000) drive_cycle();
      for (int i = 0; i < N; i++) budget[i] = 0;
      wait_idle(1000, "rand_drain");
      check("rand_progress", 64'(grants.size() > 20), 64'd1);
    end

`ifdef AXI_ARB_RESP_CHECK_EN
    // Early rlast sets err; a later error response leaves it set.
    do_reset();
    fix_len = 3; early_last = 2; budget[0] = 1;
    wait_idle(100, "err_len_done");
    check("err_after_len", 64'(err), 64'd1);
    early_last = -1; err_prob = 100; budget[1] = 1;
    wait_idle(100, "err_resp_done");
    check("err_sticky", 64'(err), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Parametrised N-master AXI4 read-channel arbiter for the CPU memory subsystem.
- Generalises the fixed icache/dcache read arbitration in the AXI bridge to NUM_MASTERS requesters, e.g. icache, dcache, uncached port, prefetcher.
- Round-robin grant; one burst outstanding at a time.
- Tags each AXI burst with arid equal to the master index.
- Sits between the cache read ports and the top-level AXI read channels (AR, R).

Parameters:
NUM_MASTERS, 2, number of read requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data beat width
ID_W, 4, AXI id width; must be >= clog2(NUM_MASTERS)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
m_araddr  in  NUM_MASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
m_arlen  in  NUM_MASTERS*8  per-master burst length minus 1
m_arsize  in  NUM_MASTERS*3  per-master beat size
m_arvalid  in  NUM_MASTERS  per-master request valid
m_arready  out  NUM_MASTERS  per-master address accept
m_rdata  out  DATA_W  read data, broadcast to all masters
m_rlast  out  1  last beat, broadcast
m_rvalid  out  NUM_MASTERS  beat valid, granted master only
m_rready  in  NUM_MASTERS  per-master beat ready
arid  out  ID_W  grant index, zero-extended
araddr  out  ADDR_W  AXI AR address
arlen  out  8  AXI AR burst length
arsize  out  3  AXI AR beat size
arburst  out  2  constant 2'b01 (INCR)
arlock  out  2  constant 0
arcache  out  4  constant 0
arprot  out  3  constant 0
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rid  in  ID_W  AXI R id
rdata  in  DATA_W  AXI R data
rresp  in  2  AXI R response
rlast  in  1  AXI R last beat
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready

Behaviour:
- Clocking/reset: one clock, aclk; reset asynchronous, active-low, aresetn.
- Reset values:
  - state=IDLE; grant=0.
  - last_grant=NUM_MASTERS-1, so master 0 wins first.
  - arvalid=0, rready=0, all m_arready/m_rvalid=0.
  - araddr/arlen/arsize/arid registers=0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any m_arvalid is high, pick the first requester scanning from last_grant+1, wrapping modulo NUM_MASTERS.
  - Register grant, araddr, arlen, arsize and arid=grant.
  - Next state ADDR. No request: stay in IDLE.
- ADDR:
  - arvalid=1 with registered fields.
  - When arready=1: m_arready[grant]=1 in that same cycle (combinational), next state DATA.
  - Requesters hold m_arvalid and their fields until m_arready; dropping early is a protocol violation, no recovery required.
- DATA:
  - rready = m_rready[grant].
  - m_rvalid[grant] = rvalid; other m_rvalid bits are 0.
  - m_rdata = rdata and m_rlast = rlast, combinational pass-through.
  - On rvalid & rready & rlast: last_grant<=grant, next state IDLE.
- Latency:
  - m_arvalid seen in IDLE at cycle n gives arvalid at cycle n+1.
  - Earliest next grant is the cycle after the last beat.
- Ordering and fields:
  - rid is not checked; the single outstanding burst guarantees ordering.
  - arburst/arlock/arcache/arprot are constants.
- Boundary conditions:
  - Requests arriving in ADDR/DATA wait; grants are evaluated only in IDLE.
  - Single requester: re-granted back-to-back, with one IDLE cycle between bursts.
  - arlen=0: first beat is also last; DATA lasts one handshake.
  - aresetn low mid-burst: immediate return to reset values; the abandoned burst is the system reset's responsibility.

Optional Feature:
AXI_ARB_RESP_CHECK_EN
- Defined:
  - Adds output port err (1 bit, sticky, reset 0) and an 8-bit beat counter, cleared on entry to DATA.
  - err sets on any handshaked beat with rresp!=2'b00.
  - err also sets when rlast arrives with beat count != arlen+1, or when a beat with count == arlen+1 lacks rlast.
  - err clears only on reset. Arbitration is unaffected.
- Undefined: no err port, no counter.

Test Plan:
- NUM_MASTERS=2; master0 araddr=0x1FC00000, arlen=3; arready after 2 cycles → arvalid one cycle after request; m_arready[0] pulses with arready; 4 beats to master0 only; m_rlast on 4th; back to IDLE.
- Masters 0 and 1 assert together, repeating → grant order 0,1,0,1; arid 0,1,0,1.
- m_rready[grant] low for 3 cycles mid-burst → rready low; no beat lost; data order preserved.
- NUM_MASTERS=3; masters 1 and 2 request while master0 bursts → order 0,1,2, then 0 wins if requesting.
- aresetn dropped in DATA with arlen=7 after beat 2 → all outputs zero asynchronously; next grant master0.
- AXI_ARB_RESP_CHECK_EN defined; arlen=3 with rlast on beat 3, then rresp=2'b10 on a later burst → err=1 after the first burst and stays 1.
